// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } state_t;

    localparam logic [3:0] ZERO = 4'd0;
    localparam logic [3:0] ONE  = 4'd1;
    localparam logic [3:0] NINE = 4'd9;

    localparam int DIGITS = 4;

endpackage

// File: rtl/stopwatch_controller_bcd_counter4.sv
// Four-digit cascaded BCD counter; wrap pulses on the 9999 -> 0000 increment.
module bcd_counter4
    import stopwatch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    output logic [15:0] value,
    output logic        wrap
);

    logic [DIGITS-1:0][3:0] digits;
    logic [DIGITS-1:0][3:0] next_digits;
    logic [DIGITS:0]        carry;

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        next_digits = digits;
        carry[0]    = enable;
        for (int i = 0; i < DIGITS; i++) begin
            carry[i+1] = carry[i] && (digits[i] == NINE);
            if (carry[i]) begin
                next_digits[i] = (digits[i] == NINE) ? ZERO : digits[i] + ONE;
            end
        end
    end

    assign wrap  = carry[DIGITS];
    assign value = digits;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digits <= '0;
        end else if (clear) begin
            digits <= '0;
        end else begin
            digits <= next_digits;
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing: run/pause/lap FSM, tick prescaler, lap snapshot, display scan.
// Optional lap feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        startStop,
    input  logic        lapIn,
    input  logic        clearIn,
    output logic [15:0] displayValue,
    output logic [3:0]  anodeOut,
    output logic [3:0]  digitOut,
    output logic        running,
    output logic        lapActive,
    output logic        wrapped
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    state_t        state;
    logic [PW-1:0] prescale;
    logic [SW-1:0] scan_count;
    logic [1:0]    digit_idx;
    logic [15:0]   count;
    logic          count_wrap;
    logic          counting;
    logic          tick;

    assign counting = (state == RUNNING) || (state == LAP);
    assign tick     = counting && (prescale == TICK_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            running   <= 1'b0;
            lapActive <= 1'b0;
        end else if (clearIn) begin
            state     <= IDLE;
            running   <= 1'b0;
            lapActive <= 1'b0;
        end else begin
            case (state)
                IDLE, PAUSED: begin
                    if (startStop) begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (startStop) begin
                        state   <= PAUSED;
                        running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
                    end else if (lapIn) begin
                        state     <= LAP;
                        lapActive <= 1'b1;
`endif
                    end
                end
`ifdef STOPWATCH_LAP_EN
                LAP: begin
                    if (startStop) begin
                        state     <= PAUSED;
                        running   <= 1'b0;
                        lapActive <= 1'b0;
                    end else if (lapIn) begin
                        state     <= RUNNING;
                        lapActive <= 1'b0;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    running   <= 1'b0;
                    lapActive <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler holds while paused so a resume finishes the partial period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescale <= '0;
        end else if (clearIn) begin
            prescale <= '0;
        end else if (counting) begin
            prescale <= (prescale == TICK_LAST) ? '0 : prescale + PW'(1);
        end
    end

    bcd_counter4 u_counter (
        .clock  (clock),
        .reset  (reset),
        .enable (tick),
        .clear  (clearIn),
        .value  (count),
        .wrap   (count_wrap)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrapped <= 1'b0;
        end else if (clearIn) begin
            wrapped <= 1'b0;
        end else if (count_wrap) begin
            wrapped <= 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [15:0] lap_value;

    // Captures the pre-increment count; startStop outranks lapIn in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lap_value <= '0;
        end else if (clearIn) begin
            lap_value <= '0;
        end else if (!startStop && lapIn && (state == RUNNING)) begin
            lap_value <= count;
        end
    end

    assign displayValue = lapActive ? lap_value : count;
`else
    logic unused_lap;
    assign unused_lap   = lapIn;
    assign displayValue = count;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_count <= '0;
            digit_idx  <= 2'd0;
        end else if (scan_count == SCAN_LAST) begin
            scan_count <= '0;
            digit_idx  <= digit_idx + 2'd1;
        end else begin
            scan_count <= scan_count + SW'(1);
        end
    end

    assign anodeOut = ~(4'b0001 << digit_idx);
    assign digitOut = displayValue[{digit_idx, 2'b00} +: 4];

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller at TICK_DIV=4, SCAN_DIV=2; expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        startStop;
    logic        lapIn;
    logic        clearIn;
    logic [15:0] displayValue;
    logic [3:0]  anodeOut;
    logic [3:0]  digitOut;
    logic        running;
    logic        lapActive;
    logic        wrapped;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_controller #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .startStop    (startStop),
        .lapIn        (lapIn),
        .clearIn      (clearIn),
        .displayValue (displayValue),
        .anodeOut     (anodeOut),
        .digitOut     (digitOut),
        .running      (running),
        .lapActive    (lapActive),
        .wrapped      (wrapped)
    );

    always #5 clock = ~clock;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse(input bit s, input bit l, input bit c);
        startStop = s;
        lapIn     = l;
        clearIn   = c;
        tick(1);
        startStop = 1'b0;
        lapIn     = 1'b0;
        clearIn   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_display"}, 32'(displayValue), 32'h0000);
        check({pfx, "_anode"},   32'(anodeOut),     32'b1110);
        check({pfx, "_digit"},   32'(digitOut),     32'd0);
        check({pfx, "_running"}, 32'(running),      32'd0);
        check({pfx, "_lap"},     32'(lapActive),    32'd0);
        check({pfx, "_wrapped"}, 32'(wrapped),      32'd0);
    endtask

    logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] exp_dg [4] = '{4'd4, 4'd3, 4'd2, 4'd1};

    initial begin
        reset     = 1'b1;
        startStop = 1'b0;
        lapIn     = 1'b0;
        clearIn   = 1'b0;
        tick(2);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(2);

        // Start: first increment exactly 4 edges after the start edge, 0x0010 after 40.
        pulse(1, 0, 0);
        check("start_running", 32'(running), 32'd1);
        tick(3);
        check("pre_first_inc", 32'(displayValue), 32'h0000);
        tick(1);
        check("first_inc", 32'(displayValue), 32'h0001);
        tick(36);
        check("run_40", 32'(displayValue), 32'h0010);
        check("run_40_running", 32'(running), 32'd1);

        // Lap snapshot and release.
        pulse(0, 0, 1);
        check("clear_idle", 32'(running), 32'd0);
        check("clear_zero", 32'(displayValue), 32'h0000);
        pulse(1, 0, 0);
        tick(12);
        check("three_ticks", 32'(displayValue), 32'h0003);
        pulse(0, 1, 0);
        check("lap_enter", 32'(lapActive), 32'(LAP_ON));
        tick(19);
        check("lap_hold", 32'(displayValue), LAP_ON ? 32'h0003 : 32'h0008);
        check("lap_running", 32'(running), 32'd1);
        pulse(0, 1, 0);
        check("lap_release", 32'(displayValue), 32'h0008);
        check("lap_release_flag", 32'(lapActive), 32'd0);

        // Lap on an increment edge keeps the pre-increment value.
        tick(2);
        pulse(0, 1, 0);
        check("lap_same_edge", 32'(displayValue), LAP_ON ? 32'h0008 : 32'h0009);
        pulse(1, 0, 0);
        check("pause_live", 32'(displayValue), 32'h0009);
        check("pause_running", 32'(running), 32'd0);
        check("pause_lapflag", 32'(lapActive), 32'd0);

        // Paused with prescaler at 1: hold, then increment on 3rd edge after resume.
        tick(100);
        check("pause_hold", 32'(displayValue), 32'h0009);
        pulse(1, 0, 0);
        tick(2);
        check("resume_pre", 32'(displayValue), 32'h0009);
        tick(1);
        check("resume_inc", 32'(displayValue), 32'h0010);

        // Lap pulse ignored while paused.
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("paused_lap_ignored", 32'(lapActive), 32'd0);

        // Rollover after 10000 ticks.
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        tick(39999);
        check("pre_wrap", 32'(displayValue), 32'h9999);
        check("pre_wrap_flag", 32'(wrapped), 32'd0);
        tick(1);
        check("wrap_value", 32'(displayValue), 32'h0000);
        check("wrap_flag", 32'(wrapped), 32'd1);
        tick(8);
        check("wrap_sticky", 32'(wrapped), 32'd1);
        pulse(1, 0, 1);
        check("clear_prio_running", 32'(running), 32'd0);
        check("clear_prio_wrapped", 32'(wrapped), 32'd0);
        tick(10);
        check("clear_prio_norun", 32'(displayValue), 32'h0000);

        // Drive to 0x1234, pause, and watch the scan.
        pulse(1, 0, 0);
        tick(4936);
        pulse(1, 0, 0);
        check("count_1234", 32'(displayValue), 32'h1234);
        for (int i = 0; i < 10 && anodeOut != 4'b1101; i++) tick(1);
        for (int i = 0; i < 10 && anodeOut != 4'b1110; i++) tick(1);
        check("scan_sync", 32'(anodeOut), 32'b1110);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("scan_an%0d", k), 32'(anodeOut), 32'(exp_an[k/2]));
            check($sformatf("scan_dg%0d", k), 32'(digitOut), 32'(exp_dg[k/2]));
            tick(1);
        end

        // Asynchronous reset in the middle of a cycle while running.
        pulse(1, 0, 0);
        tick(3);
        check("pre_reset_count", 32'(displayValue), 32'h1235);
        check("pre_reset_running", 32'(running), 32'd1);
        #3 reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        #1 reset = 1'b0;
        tick(5);
        check("post_reset_idle", 32'(running), 32'd0);
        check("post_reset_count", 32'(displayValue), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing controller for the 4-digit BCD count-and-display datapath: turns single-cycle start/stop, lap and clear pulses into a run/pause/lap state machine. It owns the tick prescaler that advances a cascaded BCD counter, holds a lap snapshot, and time-multiplexes the selected value onto the four-anode seven-segment display. It sits between the debounced button pulses and the existing seven-segment decoder.

## Interface
- TICK_DIV, 1_000_000: clock cycles per count increment (10 ms at 100 MHz); must be ≥ 2.
- SCAN_DIV, 100_000: clock cycles each digit stays selected; must be ≥ 1.
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- startStop  in  1  single-cycle pulse; toggles run/pause.
- lapIn  in  1  single-cycle pulse; freezes or releases the displayed value.
- clearIn  in  1  single-cycle pulse; returns to idle and zeroes the count.
- displayValue  out  16  four BCD digits shown ({thousands, hundreds, tens, ones}).
- anodeOut  out  4  active-low one-hot digit select; bit 0 selects ones.
- digitOut  out  4  BCD nibble for the currently selected digit.
- running  out  1  high in RUNNING or LAP.
- lapActive  out  1  high in LAP.
- wrapped  out  1  sticky; set on 9999→0000 rollover.

## Operation
- States: IDLE, RUNNING, PAUSED, LAP. Reset state is IDLE.
- Input priority when pulses coincide: clearIn > startStop > lapIn. Lower-priority pulses in the same cycle are dropped.
- clearIn, any state → IDLE. Count, lap register and prescaler go to 0; wrapped clears.
- IDLE: startStop → RUNNING. lapIn is ignored.
- RUNNING: startStop → PAUSED. lapIn → LAP and copies the live count into the lap register.
- LAP: counting continues and displayValue shows the lap register. lapIn → RUNNING. startStop → PAUSED, and the display returns to the live count.
- PAUSED: startStop → RUNNING. lapIn is ignored.
- Prescaler advances only in RUNNING/LAP, counting 0..TICK_DIV-1. It holds its value in PAUSED, so resume continues the partial period.
- When the prescaler reaches TICK_DIV-1, it returns to 0 and the count increments.
- BCD increment: each digit carries into the next only when all lower digits are 9. 9999 rolls over to 0000 and sets wrapped.
- displayValue is the lap register in LAP and the live count otherwise.
- Scan logic is free-running in all states.
  - Scan counter runs 0..SCAN_DIV-1; at SCAN_DIV-1 the digit index advances 0→1→2→3→0.
  - anodeOut = ~(4'b0001 << index).
  - digitOut = displayValue nibble[index].

## Timing
- Reset values: displayValue 0x0000, anodeOut 4'b1110, digitOut 0, running 0, lapActive 0, wrapped 0. Prescaler, scan counter and index are 0.
- All outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.
- State change is visible the cycle after the pulse edge.
- First increment after leaving IDLE: TICK_DIV cycles after the startStop edge.
- Lap latch captures the count as it is at the lapIn edge. An increment on that same edge is not captured.
- Reset asserted mid-run: every register clears immediately, with no wait for a clock edge.

## Configuration
- STOPWATCH_LAP_EN defined: the LAP state and lap register exist as described above.
- STOPWATCH_LAP_EN undefined: no LAP state and no lap register. lapIn is ignored, lapActive is tied to 0, and displayValue is always the live count.

## Structure
- Shared package stopwatch_pkg holds:
  - state enum (IDLE, RUNNING, PAUSED, LAP)
  - BCD constants ZERO = 4'd0, ONE = 4'd1, NINE = 4'd9
  - DIGITS = 4
- Sub-module bcd_counter4 contains the 4-digit cascade, with inputs enable and clear and outputs value[15:0] and wrap pulse. The FSM, prescaler, lap register and scan logic stay in the top.

## Test plan
Use TICK_DIV=4 and SCAN_DIV=2 unless noted.
- Reset, then startStop pulse, then 40 cycles → displayValue 0x0010, running=1.
- Run 3 ticks, lapIn, then 5 more ticks → displayValue holds 0x0003 and lapActive=1. A second lapIn → 0x0008.
- Pause with prescaler=1, idle 100 cycles with the count unchanged, then startStop → next increment lands on the 3rd edge after resume.
- Run 10000 ticks → displayValue 0x0000, wrapped=1. Then clearIn together with startStop → IDLE, wrapped=0, no run.
- Drive the count to 0x1234 → anodeOut cycles 1110/1101/1011/0111, 2 cycles each, with digitOut 4/3/2/1.
- Assert reset mid-cycle while RUNNING → all outputs reach reset values before the next clock edge. Build without STOPWATCH_LAP_EN → lapIn has no effect.
